act_readout_engine: RTL and testbench

//  Host-side read master that drains output activations from the accelerator after its interrupt.

---
 rtl/act_readout_engine.sv | 177 +++++++++++++++++
 tb/tb_act_readout_engine.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/act_readout_engine.sv
// act_readout_engine
//   Host-side read master that drains output activations after the
//   accelerator interrupt. It walks the PE/slot address space in PE-major
//   order, issues one-cycle read requests, buffers the returned beats in a
//   small first-word-fall-through FIFO, and streams them to the host. Each
//   returned activation index is checked against the expected sequence.
//
// Ports
//   clk, rst                 clock and synchronous active-high reset
//   start, act_no            begin a readout of act_no activations (IDLE only)
//   busy, done, seq_err      status: running, end-of-run pulse, sticky index error
//   read_en/read_rdy/
//   read_addr                read request channel to the accelerator
//   read_data_vld/rdy/data   response channel from the accelerator
//   out_vld/out_rdy/out_data host stream (FIFO head)
module act_readout_engine #(
  parameter int ADDR_W     = 16,
  parameter int RDATA_W    = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [11:0]        act_no,
  output logic               busy,
  output logic               done,
  output logic               seq_err,
  output logic               read_en,
  input  logic               read_rdy,
  output logic [ADDR_W-1:0]  read_addr,
  output logic               read_data_rdy,
  input  logic               read_data_vld,
  input  logic [RDATA_W-1:0] read_data,
  output logic               out_vld,
  input  logic               out_rdy,
  output logic [RDATA_W-1:0] out_data
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t             state;
  logic [11:0]        act_no_reg;
  logic [11:0]        issued;
  logic [11:0]        received;
  logic [11:0]        popped;
  logic [5:0]         pe_idx;
  logic [5:0]         slot;

  logic [RDATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W:0]     fifo_count;
  logic               fifo_full;
  logic               fifo_empty;
  logic               push;
  logic               pop;
  logic [12:0]        credit_used;
  logic               credit_ok;

  assign fifo_full     = (fifo_count == (PTR_W+1)'(FIFO_DEPTH));
  assign fifo_empty    = (fifo_count == '0);
  assign read_data_rdy = busy & ~fifo_full;
  assign push          = read_data_vld & read_data_rdy;
  assign out_vld       = ~fifo_empty;
  assign out_data      = mem[rd_ptr];
  assign pop           = out_vld & out_rdy;

  // Every outstanding request plus every buffered beat holds a FIFO slot,
  // so a new request is only allowed while that total is below the depth.
  assign credit_used = {1'b0, issued - received} + 13'(fifo_count);
  assign credit_ok   = (credit_used < 13'(FIFO_DEPTH));

  // Response storage; small enough for distributed RAM with an asynchronous
  // head read, which gives the one-cycle push-to-head latency.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= read_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      act_no_reg <= '0;
      issued     <= '0;
      received   <= '0;
      popped     <= '0;
      pe_idx     <= '0;
      slot       <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      seq_err    <= 1'b0;
      read_en    <= 1'b0;
      read_addr  <= '0;
    end else begin
      done <= 1'b0;

      if (push) begin
        wr_ptr   <= wr_ptr + 1'b1;
        received <= received + 12'd1;
        if (read_data[27:16] != received) begin
          seq_err <= 1'b1;
        end
      end

      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        popped <= popped + 12'd1;
      end

      fifo_count <= fifo_count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);

      case (state)
        IDLE: begin
          if (start) begin
            act_no_reg <= act_no;
            issued     <= '0;
            received   <= '0;
            popped     <= '0;
            pe_idx     <= '0;
            slot       <= '0;
            seq_err    <= 1'b0;
            if (act_no == 12'd0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= ISSUE;
              busy  <= 1'b1;
            end
          end
        end

        ISSUE: begin
          if (read_en) begin
            // The request is taken in the cycle read_en is high; drop the
            // strobe so requests are always at least two cycles apart.
            read_en   <= 1'b0;
            read_addr <= '0;
            issued    <= issued + 12'd1;
            pe_idx    <= pe_idx + 6'd1;
            if (pe_idx == 6'd63) begin
              slot <= slot + 6'd1;
            end
            if (issued + 12'd1 == act_no_reg) begin
              state <= DRAIN;
            end
          end else if (read_rdy && credit_ok) begin
            read_en   <= 1'b1;
            read_addr <= ADDR_W'({pe_idx, 4'b0000, slot});
          end
        end

        DRAIN: begin
          if (pop && (popped + 12'd1 == act_no_reg)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_act_readout_engine.sv
module tb_act_readout_engine;

  localparam int ADDR_W     = 16;
  localparam int RDATA_W    = 32;
  localparam int FIFO_DEPTH = 8;
  localparam int BUDGET     = 4000;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [11:0]        act_no;
  logic               busy;
  logic               done;
  logic               seq_err;
  logic               read_en;
  logic               read_rdy;
  logic [ADDR_W-1:0]  read_addr;
  logic               read_data_rdy;
  logic               read_data_vld;
  logic [RDATA_W-1:0] read_data;
  logic               out_vld;
  logic               out_rdy;
  logic [RDATA_W-1:0] out_data;

  act_readout_engine #(
    .ADDR_W(ADDR_W), .RDATA_W(RDATA_W), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .act_no(act_no),
    .busy(busy), .done(done), .seq_err(seq_err),
    .read_en(read_en), .read_rdy(read_rdy), .read_addr(read_addr),
    .read_data_rdy(read_data_rdy), .read_data_vld(read_data_vld),
    .read_data(read_data),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model / responder state
  int          req_cnt, acc_cnt, pop_cnt, done_cnt, cyc, done_cyc;
  int          req_q[$];
  logic [31:0] exp_q[$];
  bit          prev_read_en, beat_active, busy_seen, seq_err_at_done;
  int          bad_k, bad_val;
  int          rdy_pct, rsp_pct, out_pct, hold_out;

  // PE-major walk: 64 PEs per slot, PE index in bits 15:10, slot in 5:0.
  function automatic logic [15:0] exp_addr(input int k);
    int pe, sl;
    pe = k % 64;
    sl = (k / 64) % 64;
    return 16'((pe << 10) | sl);
  endfunction

  task automatic cycle();
    logic [31:0] d;
    logic [11:0] idx;
    int          k;
    @(negedge clk);
    if (read_en) begin
      check("read_addr", 64'(read_addr), 64'(exp_addr(req_cnt)));
      if (prev_read_en) check("req_spacing", 1, 0);
      req_q.push_back(req_cnt);
      req_cnt++;
    end else if (prev_read_en) begin
      check("addr_idle", 64'(read_addr), 0);
    end
    prev_read_en = read_en;
    if (busy) busy_seen = 1;
    if (read_data_vld && read_data_rdy) begin
      exp_q.push_back(read_data);
      acc_cnt++;
      beat_active = 0;
    end
    if (out_vld && out_rdy) begin
      if (exp_q.size() == 0) begin
        check("pop_empty", 1, 0);
      end else begin
        d = exp_q.pop_front();
        check("out_data", 64'(out_data), 64'(d));
        $display("pop %0d data=0x%08h", pop_cnt, out_data);
      end
      pop_cnt++;
    end
    if (req_cnt - pop_cnt > FIFO_DEPTH) check("credit", req_cnt - pop_cnt, FIFO_DEPTH);
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      seq_err_at_done = seq_err;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (!beat_active) begin
      if (req_q.size() > 0 && $urandom_range(99) < rsp_pct) begin
        k   = req_q.pop_front();
        idx = (k == bad_k) ? 12'(bad_val) : 12'(k);
        read_data     = {4'h0, idx, 16'($urandom)};
        read_data_vld = 1'b1;
        beat_active   = 1;
      end else begin
        read_data_vld = 1'b0;
      end
    end
    read_rdy = ($urandom_range(99) < rdy_pct);
    out_rdy  = (cyc < hold_out) ? 1'b0 : ($urandom_range(99) < out_pct);
  endtask

  task automatic clear_model();
    req_cnt = 0; acc_cnt = 0; pop_cnt = 0; done_cnt = 0; done_cyc = -1;
    req_q.delete(); exp_q.delete();
    prev_read_en = 0; beat_active = 0; busy_seen = 0; seq_err_at_done = 0;
    read_data_vld = 1'b0;
  endtask

  task automatic run(input string name, input int n, input int rp, input int sp,
                     input int op, input int hold, input int bk, input int bv);
    bit exp_err;
    clear_model();
    rdy_pct = rp; rsp_pct = sp; out_pct = op; hold_out = hold;
    bad_k = bk; bad_val = bv;
    exp_err = (bk >= 0) && (bk < n) && (bv != bk);
    cyc = 0;
    start  = 1'b1;
    act_no = 12'(n);
    cycle();
    start = 1'b0;
    check({name, "_busy_after_start"}, 64'(busy), 64'(n != 0));
    check({name, "_seq_err_cleared"}, 64'(seq_err), 0);
    while (done_cnt == 0 && cyc < BUDGET) begin
      if (hold > 0 && cyc == hold) begin
        check({name, "_stall_issued"}, req_cnt, FIFO_DEPTH);
        check({name, "_stall_out_vld"}, 64'(out_vld), 1);
      end
      cycle();
    end
    if (done_cnt == 0) check({name, "_timeout"}, cyc, 0);
    for (int i = 0; i < 5; i++) cycle();
    check({name, "_done_count"}, done_cnt, 1);
    check({name, "_requests"}, req_cnt, n);
    check({name, "_popped"}, pop_cnt, n);
    check({name, "_seq_err_at_done"}, 64'(seq_err_at_done), 64'(exp_err));
    check({name, "_seq_err_after"}, 64'(seq_err), 64'(exp_err));
    check({name, "_busy_idle"}, 64'(busy), 0);
    check({name, "_out_vld_idle"}, 64'(out_vld), 0);
    if (n == 0) begin
      check({name, "_done_latency"}, done_cyc, 1);
      check({name, "_busy_never"}, 64'(busy_seen), 0);
    end
    $display("run %s act_no=%0d requests=%0d popped=%0d seq_err=%0b", name, n, req_cnt, pop_cnt, seq_err);
  endtask

  task automatic abort_run();
    clear_model();
    rdy_pct = 100; rsp_pct = 100; out_pct = 50; hold_out = 0;
    bad_k = -1; bad_val = 0;
    cyc = 0;
    start  = 1'b1;
    act_no = 12'd10;
    cycle();
    start = 1'b0;
    while (acc_cnt < 4 && cyc < BUDGET) cycle();
    if (acc_cnt < 4) check("abort_timeout", acc_cnt, 4);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("abort_busy", 64'(busy), 0);
    check("abort_read_en", 64'(read_en), 0);
    check("abort_out_vld", 64'(out_vld), 0);
    check("abort_done", 64'(done), 0);
    // A response still in flight after reset must be refused.
    read_data     = 32'h0005_1234;
    read_data_vld = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_rsp_refused", 64'(read_data_rdy), 0);
      check("abort_no_req", 64'(read_en), 0);
    end
    @(posedge clk);
    #1;
    read_data_vld = 1'b0;
    $display("run abort after %0d beats", acc_cnt);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; act_no = '0; read_rdy = 1'b0;
    read_data_vld = 1'b0; read_data = '0; out_rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 0);
    check("rst_done", 64'(done), 0);
    check("rst_seq_err", 64'(seq_err), 0);
    check("rst_read_en", 64'(read_en), 0);
    check("rst_out_vld", 64'(out_vld), 0);
    check("rst_read_addr", 64'(read_addr), 0);
    check("rst_read_data_rdy", 64'(read_data_rdy), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    run("t1", 3, 100, 100, 100, 0, -1, 0);
    run("t2", 65, 100, 100, 100, 0, -1, 0);
    run("t3", 20, 100, 100, 100, 60, -1, 0);
    run("t4", 12, 100, 100, 100, 0, 2, 5);
    run("t4_clear", 3, 100, 100, 100, 0, -1, 0);
    run("t5", 0, 100, 100, 100, 0, -1, 0);
    abort_run();
    run("t6_clean", 10, 100, 100, 100, 0, -1, 0);
    for (int i = 0; i < 4; i++) begin
      int n, bk;
      n  = $urandom_range(150, 1);
      bk = (i == 1) ? int'($urandom_range(n - 1, 0)) : -1;
      run($sformatf("rand%0d", i), n, $urandom_range(100, 30), $urandom_range(100, 40),
          $urandom_range(100, 30), 0, bk, bk + 7);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
